// File: rtl/aoi_share_arbiter.sv
// aoi_share_arbiter: round-robin share of one AOI21 unit d = ~((a & b) | c) among N_REQ requesters.
// Latency: accept -> rsp_valid after LAT cycles; one transaction in flight, issue period LAT+2.
// Backpressure: rsp_ready=0 holds the response and blocks new grants; req_ready only asserts in IDLE.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   en                         grant enable (in-flight work always completes)
//   req_valid/req_a/b/c        per-requester valid and single-bit operands
//   req_ready                  one-hot combinational grant, IDLE only
//   rsp_valid/rsp_d/rsp_id     registered response, held until rsp_ready
//   busy                       FSM not in IDLE
//   txn_count                  completed responses, wrapping 16-bit counter
module aoi_share_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int LAT   = 1,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0] req_c,
  output logic [N_REQ-1:0] req_ready,
  output logic             rsp_valid,
  output logic             rsp_d,
  output logic [IDW-1:0]   rsp_id,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [15:0]      txn_count
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   rr_next;
  logic             found;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [LAT-1:0]   pipe;
  logic             aoi_in;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign rr_next = IDW'((int'(winner) + 1) % N_REQ);
  assign aoi_in  = ~((req_a[winner] & req_b[winner]) | req_c[winner]);
  assign busy    = (state_q != IDLE);

  // Next-state and grant; ready is only raised towards a valid winner, so
  // ready implies a transfer in that cycle.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          state_d           = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      cnt       <= '0;
      pipe      <= '0;
      rsp_valid <= 1'b0;
      rsp_d     <= 1'b0;
      rsp_id    <= '0;
      txn_count <= '0;
    end else begin
      state_q <= state_d;

      // AOI datapath stages advance every cycle; stage 0 loads on accept.
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end

      if (accept) begin
        pipe[0] <= aoi_in;
        id_q    <= winner;
        rr_ptr  <= rr_next;
        cnt     <= CW'(LAT - 1);
      end

      // Counter reaching zero coincides with the result arriving at the last stage.
      if (state_q == BUSY) begin
        if (cnt == '0) begin
          rsp_valid <= 1'b1;
          rsp_d     <= pipe[LAT-1];
          rsp_id    <= id_q;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end

      if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        txn_count <= txn_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aoi_share_arbiter.sv
module tb_aoi_share_arbiter;
  localparam int N    = 4;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (LAT=1)
  logic         rst_n, en, rsp_ready;
  logic [N-1:0] req_valid, req_a, req_b, req_c, req_ready;
  logic         rsp_valid, rsp_d, busy;
  logic [1:0]   rsp_id;
  logic [15:0]  txn_count;

  // Second DUT (LAT=3) for the reset-in-BUSY and latency checks
  logic         rst3_n, en3, rsp_ready3;
  logic [N-1:0] req_valid3, req_a3, req_b3, req_c3, req_ready3;
  logic         rsp_valid3, rsp_d3, busy3;
  logic [1:0]   rsp_id3;
  logic [15:0]  txn_count3;

  aoi_share_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_d(rsp_d), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy), .txn_count(txn_count)
  );

  aoi_share_arbiter #(.N_REQ(N), .LAT(LAT3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .en(en3),
    .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3), .req_c(req_c3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_d(rsp_d3), .rsp_id(rsp_id3),
    .rsp_ready(rsp_ready3), .busy(busy3), .txn_count(txn_count3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    bit d;
  } exp_t;
  exp_t q[$];

  // Reference model: pending requests and the round-robin pointer
  logic [N-1:0] m_valid, m_a, m_b, m_c;
  int  m_ptr     = 0;
  int  n_issued  = 0;
  int  rdy_mode  = 1;   // 0: hold low, 1: hold high, 2: random
  bit  mon_on    = 0;
  bit  watch3    = 0;
  bit  saw3      = 0;
  time acc_t     = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit aoi(input bit a, input bit b, input bit c);
    return ~((a & b) | c);
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (m_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = m_valid;
    req_a     = m_a;
    req_b     = m_b;
    req_c     = m_c;
  endtask

  task automatic set_req(input int r);
    m_valid[r] = 1'b1;
    m_a[r]     = 1'($urandom_range(0, 1));
    m_b[r]     = 1'($urandom_range(0, 1));
    m_c[r]     = 1'($urandom_range(0, 1));
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Waits for the DUT grant, checks it against the model's winner, records
  // the expected response, and retires the request after the accept edge.
  task automatic grant_one(input bit refill);
    int   w;
    int   n;
    exp_t e;
    w = pick();
    if (w < 0) return;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got no grant, expected requester %0d", w);
      return;
    end
    chk("grant_onehot", int'(req_ready), 1 << w);
    e.id = w;
    e.d  = aoi(m_a[w], m_b[w], m_c[w]);
    q.push_back(e);
    n_issued++;
    @(posedge clk);
    acc_t = $time;
    #1;
    m_valid[w] = 1'b0;
    if (refill) set_req(w);
    m_ptr = (w + 1) % N;
    drive();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy || rsp_valid) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0d rsp_valid=%0d, expected both 0", busy, rsp_valid);
    end
  endtask

  task automatic drain();
    while (pick() >= 0) grant_one(1'b0);
  endtask

  // Consumer-side ready generator
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every cycle a response is shown it must match the queue head;
  // the head retires on handshake.
  always @(negedge clk) begin
    if (mon_on && rsp_valid) begin
      chk("ready_low_in_resp", int'(req_ready), 0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d d=%0d, expected no response", rsp_id, rsp_d);
      end else begin
        chk("rsp_id", int'(rsp_id), q[0].id);
        chk("rsp_d", int'(rsp_d), int'(q[0].d));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (watch3 && rsp_valid3) saw3 = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    time prev_t;

    // ---------------- reset ----------------
    rst_n = 1'b0; rst3_n = 1'b0; en = 1'b1; en3 = 1'b1; rsp_ready3 = 1'b1;
    m_valid = '0; m_a = '0; m_b = '0; m_c = '0;
    drive();
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_c3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_txn_count", int'(txn_count), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_rsp_d", int'(rsp_d), 0);
    chk("reset_req_ready", int'(req_ready), 0);
    sync();
    rst_n = 1'b1; rst3_n = 1'b1; mon_on = 1'b1;

    // ---------------- single request, requester 2, a=1 b=1 c=0 ----------------
    sync();
    m_valid[2] = 1'b1; m_a[2] = 1'b1; m_b[2] = 1'b1; m_c[2] = 1'b0;
    drive();
    grant_one(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk("first_latency", n, LAT + 1);
    wait_idle();

    // ---------------- truth table on requester 0 ----------------
    for (int v = 0; v < 8; v++) begin
      sync();
      m_valid[0] = 1'b1;
      m_a[0] = v[2]; m_b[0] = v[1]; m_c[0] = v[0];
      drive();
      grant_one(1'b0);
      wait_idle();
    end

    // ---------------- continuous valid, rotation and issue period ----------------
    sync();
    set_req(3);
    drive();
    grant_one(1'b0);             // leaves the pointer at 0
    for (int r = 0; r < N; r++) set_req(r);
    drive();
    prev_t = 0;
    for (int k = 0; k < 6; k++) begin
      chk("rotation_model", pick(), k % N);
      grant_one(1'b1);
      if (k > 0) chk("issue_period", int'((acc_t - prev_t) / 10), LAT + 2);
      prev_t = acc_t;
    end
    drain();
    wait_idle();
    chk("txn_after_rotation", int'(txn_count), n_issued);

    // ---------------- backpressure ----------------
    rdy_mode = 0;
    sync();
    sync();
    begin
      int r;
      r = $urandom_range(0, N - 1);
      set_req(r);
      drive();
      grant_one(1'b0);
      for (int j = 0; j < N; j++) if (j != r) set_req(j);
      drive();
    end
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid_seen", int'(rsp_valid), 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_busy", int'(busy), 1);
    end
    chk("bp_one_outstanding", q.size(), 1);
    rdy_mode = 1;
    drain();
    wait_idle();

    // ---------------- enable control ----------------
    sync();
    en = 1'b0;
    for (int j = 0; j < N; j++) if ($urandom_range(0, 1) != 0) set_req(j);
    if (m_valid == '0) set_req(1);
    drive();
    repeat (6) begin
      @(negedge clk);
      chk("en0_no_grant", int'(req_ready), 0);
      chk("en0_idle", int'(busy), 0);
    end
    sync();
    en = 1'b1;
    grant_one(1'b0);             // resumes at the model pointer
    drain();
    wait_idle();

    // en dropped while BUSY: current transaction completes, then nothing new
    sync();
    set_req(0);
    set_req(2);
    drive();
    grant_one(1'b0);
    en = 1'b0;
    wait_idle();
    chk("en_drop_completed", q.size(), 0);
    repeat (5) begin
      @(negedge clk);
      chk("en_drop_no_grant", int'(req_ready), 0);
    end
    sync();
    en = 1'b1;
    drain();
    wait_idle();

    // ---------------- randomized traffic with random backpressure ----------------
    rdy_mode = 2;
    sync();
    for (int it = 0; it < 60; it++) begin
      for (int j = 0; j < N; j++) if (!m_valid[j] && $urandom_range(0, 1) != 0) set_req(j);
      if (m_valid == '0) set_req($urandom_range(0, N - 1));
      drive();
      grant_one(1'b0);
    end
    drain();
    rdy_mode = 1;
    wait_idle();
    chk("final_queue_empty", q.size(), 0);
    chk("final_txn_count", int'(txn_count), n_issued);

    // ---------------- LAT=3: reset while BUSY ----------------
    sync();
    req_valid3 = 4'b0010; req_a3 = 4'b0010; req_b3 = 4'b0010; req_c3 = 4'b0000;
    @(negedge clk);
    chk("l3_grant", int'(req_ready3), 2);
    @(posedge clk);
    watch3 = 1'b1;
    #1;
    req_valid3 = '0;
    @(negedge clk);
    chk("l3_busy_before_reset", int'(busy3), 1);
    rst3_n = 1'b0;
    @(negedge clk);
    chk("l3_reset_idle", int'(busy3), 0);
    chk("l3_reset_rsp_valid", int'(rsp_valid3), 0);
    chk("l3_reset_txn", int'(txn_count3), 0);
    sync();
    rst3_n = 1'b1;
    repeat (6) @(negedge clk);
    watch3 = 1'b0;
    chk("l3_dropped_never_reported", int'(saw3), 0);
    chk("l3_txn_still_zero", int'(txn_count3), 0);

    // LAT=3 normal transaction: requester 3, a=1 b=0 c=0 -> d=1
    sync();
    req_valid3 = 4'b1000; req_a3 = 4'b1000; req_b3 = 4'b0000; req_c3 = 4'b0000;
    @(negedge clk);
    chk("l3_grant_after_reset", int'(req_ready3), 8);
    @(posedge clk);
    #1;
    req_valid3 = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid3 && n < 20);
    chk("l3_latency", n, LAT3 + 1);
    chk("l3_rsp_d", int'(rsp_d3), 1);
    chk("l3_rsp_id", int'(rsp_id3), 3);
    @(negedge clk);
    chk("l3_txn_count", int'(txn_count3), 1);
    chk("l3_back_idle", int'(busy3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
